pll_lock_sequencer: RTL

//  Control-side counterpart of the PolarFire CCC/PLL wrapper: drives the PLL's

---
 rtl/pll_seq_pkg.sv | 37 +++
 rtl/sync_2ff.sv | 26 ++
 rtl/pll_lock_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared constants for the PLL lock sequencer: state codes, default timing and counter widths.
package pll_seq_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_PWRDN     = 3'd1;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
  localparam logic [2:0] ST_QUALIFY   = 3'd3;
  localparam logic [2:0] ST_RST_HOLD  = 3'd4;
  localparam logic [2:0] ST_RUN       = 3'd5;
  localparam logic [2:0] ST_FAULT     = 3'd6;

  localparam int unsigned DEF_PD_CYCLES        = 64;
  localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 65536;
  localparam int unsigned DEF_RST_HOLD_CYC     = 16;
  localparam int unsigned DEF_MAX_RETRIES      = 3;

  localparam int unsigned LOSS_CNT_W = 8;

  function automatic int unsigned max4_u(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // The lock-wait attempt spans WAIT_LOCK and QUALIFY so a chattering lock still times out.
  function automatic logic in_lock_wait(input state_t s);
    return (s == ST_WAIT_LOCK) || (s == ST_QUALIFY);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchronizer with asynchronous active-low reset to 0.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL power-up and lock-qualification sequencer, clocked from the free-running reference clock.
// Gates the downstream fabric reset on a qualified lock and counts lock-loss events.
//   state     | meaning
//   OFF       | disabled, PLL powered down
//   PWRDN     | POWERDOWN_N held low for PD_CYCLES
//   WAIT_LOCK | PLL running, waiting for lock or timeout
//   QUALIFY   | counting consecutive locked cycles
//   RST_HOLD  | lock qualified, fabric reset still held
//   RUN       | fabric reset released, READY
//   FAULT     | retries exhausted, PLL powered down
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PD_CYCLES        = DEF_PD_CYCLES,
  parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int unsigned RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
  parameter int unsigned MAX_RETRIES      = DEF_MAX_RETRIES
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic                  RESTART,
  input  logic                  PLL_LOCK,
  output logic                  PLL_POWERDOWN_N,
  output logic                  FABRIC_RESET_N,
  output logic                  READY,
  output logic                  FAULT,
  output logic [2:0]            STATE,
  output logic [LOSS_CNT_W-1:0] LOCK_LOSS_CNT
);

  localparam int unsigned TMR_MAX = max4_u(PD_CYCLES, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC, RST_HOLD_CYC);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int unsigned RTY_W   = $clog2(MAX_RETRIES + 1) + 1;

  localparam logic [TMR_W-1:0] PD_LAST      = TMR_W'(PD_CYCLES - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(RST_HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_SAT      = '1;
  localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);
  localparam logic [RTY_W-1:0] RTY_MAX      = RTY_W'(MAX_RETRIES);
  localparam logic [RTY_W-1:0] RTY_ONE      = RTY_W'(1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_ONE = LOSS_CNT_W'(1);

  state_t                  state_q, state_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [TMR_W-1:0]        att_q, att_d;
  logic [RTY_W-1:0]        retry_q, retry_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic                    pd_n_q, pd_n_d;
  logic                    fab_rst_n_q, fab_rst_n_d;
  logic                    ready_q, ready_d;
  logic                    fault_q, fault_d;
  logic                    lock_s;
  logic                    restart_evt;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d     (PLL_LOCK),
    .q     (lock_s)
  );

  assign restart_evt = ENABLE && RESTART;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (!ENABLE) begin
      state_d = ST_OFF;
      retry_d = '0;
    end else if (RESTART) begin
      state_d = ST_PWRDN;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_OFF:   state_d = ST_PWRDN;
        ST_PWRDN: if (tmr_q >= PD_LAST) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_QUALIFY;
          end else if (att_q >= TIMEOUT_LAST) begin
            retry_d = retry_q + RTY_ONE;
            state_d = (retry_q < RTY_MAX) ? ST_PWRDN : ST_FAULT;
          end
        end
        ST_QUALIFY: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (tmr_q >= STABLE_LAST) begin
            state_d = ST_RST_HOLD;
            retry_d = '0;
          end
        end
        ST_RST_HOLD: begin
          if (!lock_s) state_d = ST_WAIT_LOCK;
          else if (tmr_q >= HOLD_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_PWRDN;
            if (loss_q != '1) loss_d = loss_q + LOSS_ONE;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_OFF;
      endcase
    end
  end

  always_comb begin
    if ((state_d != state_q) || restart_evt) tmr_d = '0;
    else if (tmr_q == TMR_SAT)               tmr_d = tmr_q;
    else                                     tmr_d = tmr_q + TMR_ONE;

    if (!(in_lock_wait(state_q) && in_lock_wait(state_d)) || restart_evt) att_d = '0;
    else if (att_q == TMR_SAT)                                           att_d = att_q;
    else                                                                 att_d = att_q + TMR_ONE;
  end

  // Outputs are registered from the next state so they change on the same edge as STATE.
  always_comb begin
    pd_n_d      = state_d inside {ST_WAIT_LOCK, ST_QUALIFY, ST_RST_HOLD, ST_RUN};
    fab_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_OFF;
      tmr_q       <= '0;
      att_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pd_n_q      <= 1'b0;
      fab_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      att_q       <= att_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pd_n_q      <= pd_n_d;
      fab_rst_n_q <= fab_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign PLL_POWERDOWN_N = pd_n_q;
  assign FABRIC_RESET_N  = fab_rst_n_q;
  assign READY           = ready_q;
  assign FAULT           = fault_q;
  assign STATE           = state_q;
  assign LOCK_LOSS_CNT   = loss_q;

endmodule
